// File: rtl/hand_presence_detector_if.sv
// Sensor-side bundle for hand_presence_detector: per-channel sample strobes/data in,
// valve request, presence and fault status out.
interface hand_presence_detector_if #(
    parameter int CHANNELS   = 2,
    parameter int DIST_WIDTH = 16,
    parameter int GAIN_WIDTH = 8
);
  logic [CHANNELS-1:0]            acceptDistance;
  logic [CHANNELS*DIST_WIDTH-1:0] distance;
  logic [CHANNELS-1:0]            acceptGain;
  logic [CHANNELS*GAIN_WIDTH-1:0] gain;
  logic                           waterOn;
  logic [CHANNELS-1:0]            channelActive;
  logic                           timeoutFault;

  modport master (
    output acceptDistance, distance, acceptGain, gain,
    input  waterOn, channelActive, timeoutFault
  );

  modport slave (
    input  acceptDistance, distance, acceptGain, gain,
    output waterOn, channelActive, timeoutFault
  );
endinterface

// File: rtl/hand_presence_detector.sv
// Multi-channel hand presence detector: capture -> product -> hysteresis -> valve FSM.
// Capture edge to waterOn change is 3 cycles; no backpressure, samples accepted on strobe rising edges.
module hand_presence_detector #(
    parameter int CHANNELS          = 2,
    parameter int DIST_WIDTH        = 16,
    parameter int GAIN_WIDTH        = 8,
    parameter int THRESHOLD         = 1500,
    parameter int RELEASE_THRESHOLD = 1800,
    parameter int HOLD_CYCLES       = 16,
    parameter int MAX_ON_CYCLES     = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  hand_presence_detector_if.slave bus
);

  localparam int PW     = DIST_WIDTH + GAIN_WIDTH;
  localparam int ON_W   = $clog2(MAX_ON_CYCLES + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [PW-1:0]     THR       = PW'(THRESHOLD);
  localparam logic [PW-1:0]     REL       = PW'(RELEASE_THRESHOLD);
  localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(MAX_ON_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ON, HOLD, LOCKOUT} state_t;

  logic [CHANNELS-1:0]   dstb_q, dstb_d, gstb_q, gstb_d;
  logic [CHANNELS-1:0]   active_q, active_d;
  logic [DIST_WIDTH-1:0] dist_q [CHANNELS];
  logic [DIST_WIDTH-1:0] dist_d [CHANNELS];
  logic [GAIN_WIDTH-1:0] gain_q [CHANNELS];
  logic [GAIN_WIDTH-1:0] gain_d [CHANNELS];
  logic [PW-1:0]         prod_q [CHANNELS];
  logic [PW-1:0]         prod_d [CHANNELS];

  state_t            state_q, state_d;
  logic [ON_W-1:0]   on_cnt_q, on_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              water_on_q, water_on_d;
  logic              fault_q, fault_d;
  logic              any_active;

  // Per-channel capture on strobe rising edge, full-width product, then hysteresis.
  always_comb begin
    dstb_d   = bus.acceptDistance;
    gstb_d   = bus.acceptGain;
    active_d = active_q;
    for (int i = 0; i < CHANNELS; i++) begin
      dist_d[i] = dist_q[i];
      gain_d[i] = gain_q[i];
      if (bus.acceptDistance[i] && !dstb_q[i])
        dist_d[i] = bus.distance[i*DIST_WIDTH +: DIST_WIDTH];
      if (bus.acceptGain[i] && !gstb_q[i])
        gain_d[i] = bus.gain[i*GAIN_WIDTH +: GAIN_WIDTH];
      prod_d[i] = PW'(dist_q[i]) * PW'(gain_q[i]);
      if (prod_q[i] < THR)
        active_d[i] = 1'b1;
      else if (prod_q[i] >= REL)
        active_d[i] = 1'b0;
    end
  end

  assign any_active = |active_q;

  always_comb begin
    state_d    = state_q;
    on_cnt_d   = on_cnt_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_active) begin
          state_d  = ON;
          on_cnt_d = '0;
        end
      end
      ON: begin
        on_cnt_d = on_cnt_q + 1'b1;
        // Safety timeout wins over a simultaneous release.
        if (on_cnt_q == ON_LAST) begin
          state_d = LOCKOUT;
        end else if (!any_active) begin
          if (HOLD_CYCLES == 0) begin
            state_d  = IDLE;
            on_cnt_d = '0;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = HOLD_INIT;
          end
        end
      end
      HOLD: begin
        on_cnt_d = on_cnt_q + 1'b1;
        if (on_cnt_q == ON_LAST) begin
          state_d = LOCKOUT;
        end else if (any_active) begin
          state_d = ON;
        end else if (hold_cnt_q == '0) begin
          state_d  = IDLE;
          on_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      LOCKOUT: begin
        on_cnt_d = '0;
        if (!any_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    water_on_d = (state_d == ON) || (state_d == HOLD);
    fault_d    = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dstb_q     <= '0;
      gstb_q     <= '0;
      active_q   <= '0;
      state_q    <= IDLE;
      on_cnt_q   <= '0;
      hold_cnt_q <= '0;
      water_on_q <= 1'b0;
      fault_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        dist_q[i] <= '1;
        gain_q[i] <= GAIN_WIDTH'(1);
        prod_q[i] <= '1;
      end
    end else begin
      dstb_q     <= dstb_d;
      gstb_q     <= gstb_d;
      active_q   <= active_d;
      state_q    <= state_d;
      on_cnt_q   <= on_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      water_on_q <= water_on_d;
      fault_q    <= fault_d;
      for (int i = 0; i < CHANNELS; i++) begin
        dist_q[i] <= dist_d[i];
        gain_q[i] <= gain_d[i];
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign bus.waterOn       = water_on_q;
  assign bus.channelActive = active_q;
  assign bus.timeoutFault  = fault_q;

endmodule

// File: tb/tb_hand_presence_detector.sv
// Directed bench for hand_presence_detector: capture, hysteresis, hold-off, re-entry,
// timeout lockout, simultaneous strobes and asynchronous reset.
module tb_hand_presence_detector;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic seen_low;

  hand_presence_detector_if #(.CHANNELS(2), .DIST_WIDTH(16), .GAIN_WIDTH(8)) bus ();

  hand_presence_detector #(
    .CHANNELS(2), .DIST_WIDTH(16), .GAIN_WIDTH(8), .THRESHOLD(1500),
    .RELEASE_THRESHOLD(1800), .HOLD_CYCLES(16), .MAX_ON_CYCLES(1000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_dist(input int ch, input logic [15:0] v);
    bus.distance[ch*16 +: 16] = v;
  endtask

  task automatic set_gain(input int ch, input logic [7:0] v);
    bus.gain[ch*8 +: 8] = v;
  endtask

  // One-cycle distance strobe on ch; returns just after the capture edge.
  task automatic pulse_dist(input int ch, input logic [15:0] v);
    set_dist(ch, v);
    bus.acceptDistance[ch] = 1'b1;
    tick(1);
    bus.acceptDistance[ch] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.acceptDistance = '0;
    bus.acceptGain     = '0;
    bus.distance       = '0;
    bus.gain           = '0;
    tick(2);
    check("rst_waterOn", 32'(bus.waterOn), 32'd0);
    check("rst_active", 32'(bus.channelActive), 32'd0);
    check("rst_fault", 32'(bus.timeoutFault), 32'd0);
    reset = 1'b0;
    tick(1);

    // Large products on both channels: nothing activates.
    set_dist(0, 16'd3000); set_gain(0, 8'd152);
    set_dist(1, 16'd6000); set_gain(1, 8'd119);
    bus.acceptDistance = 2'b11;
    bus.acceptGain     = 2'b11;
    tick(1);
    bus.acceptDistance = 2'b00;
    bus.acceptGain     = 2'b00;
    tick(5);
    check("big_prod_active", 32'(bus.channelActive), 32'd0);
    check("big_prod_water", 32'(bus.waterOn), 32'd0);

    // ch0 gain=1 -> product 3000, still above release.
    set_gain(0, 8'd1);
    bus.acceptGain = 2'b01;
    tick(1);
    bus.acceptGain = 2'b00;
    tick(4);
    check("g1_active", 32'(bus.channelActive), 32'd0);

    // distance=1200 with strobe held 4 cycles; data changes under the held strobe.
    set_dist(0, 16'd1200);
    bus.acceptDistance = 2'b01;
    tick(1);
    set_dist(0, 16'd5000);
    check("e0_active", 32'(bus.channelActive), 32'd0);
    tick(2);
    check("e2_active", 32'(bus.channelActive), 32'd1);
    check("e2_water", 32'(bus.waterOn), 32'd0);
    tick(1);
    check("e3_water", 32'(bus.waterOn), 32'd1);
    bus.acceptDistance = 2'b00;
    tick(4);
    check("held_single_capture", 32'(bus.channelActive), 32'd1);

    // Hysteresis band keeps presence; 2000 releases, then 16-cycle hold-off.
    pulse_dist(0, 16'd1600);
    tick(4);
    check("hyst_band_active", 32'(bus.channelActive), 32'd1);
    check("hyst_band_water", 32'(bus.waterOn), 32'd1);
    pulse_dist(0, 16'd2000);
    tick(2);
    check("release_active", 32'(bus.channelActive), 32'd0);
    tick(1);
    check("hold_enter_water", 32'(bus.waterOn), 32'd1);
    tick(15);
    check("hold_last_water", 32'(bus.waterOn), 32'd1);
    tick(1);
    check("hold_done_water", 32'(bus.waterOn), 32'd0);

    // Re-entry during HOLD via ch1.
    pulse_dist(0, 16'd1200);
    tick(3);
    check("reentry_on", 32'(bus.waterOn), 32'd1);
    pulse_dist(0, 16'd2000);
    tick(3);
    tick(5);
    set_dist(1, 16'd1000); set_gain(1, 8'd1);
    bus.acceptDistance = 2'b10;
    bus.acceptGain     = 2'b10;
    seen_low = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick(1);
      bus.acceptDistance = 2'b00;
      bus.acceptGain     = 2'b00;
      if (bus.waterOn !== 1'b1) seen_low = 1'b1;
    end
    check("reentry_no_drop", 32'(seen_low), 32'd0);
    check("reentry_active", 32'(bus.channelActive), 32'd2);
    pulse_dist(1, 16'd2000);
    tick(18);
    check("reentry_hold_last", 32'(bus.waterOn), 32'd1);
    tick(1);
    check("reentry_idle", 32'(bus.waterOn), 32'd0);

    // Max-on timeout: lockout at cycle 1000 of the session.
    pulse_dist(0, 16'd100);
    tick(3);
    check("to_start_water", 32'(bus.waterOn), 32'd1);
    check("to_start_fault", 32'(bus.timeoutFault), 32'd0);
    tick(999);
    check("to_999_water", 32'(bus.waterOn), 32'd1);
    tick(1);
    check("to_1000_water", 32'(bus.waterOn), 32'd0);
    check("to_1000_fault", 32'(bus.timeoutFault), 32'd1);
    tick(3);
    check("lockout_held_fault", 32'(bus.timeoutFault), 32'd1);
    pulse_dist(0, 16'd2000);
    tick(2);
    check("lockout_e2_fault", 32'(bus.timeoutFault), 32'd1);
    check("lockout_e2_active", 32'(bus.channelActive), 32'd0);
    tick(1);
    check("lockout_exit_fault", 32'(bus.timeoutFault), 32'd0);
    tick(3);
    check("lockout_idle_water", 32'(bus.waterOn), 32'd0);

    // Simultaneous strobes: only both-new gives an active product (10*10).
    set_gain(0, 8'd200);
    bus.acceptGain = 2'b01;
    tick(1);
    bus.acceptGain = 2'b00;
    tick(4);
    check("g200_active", 32'(bus.channelActive), 32'd0);
    set_dist(0, 16'd10); set_gain(0, 8'd10);
    bus.acceptDistance = 2'b01;
    bus.acceptGain     = 2'b01;
    tick(1);
    bus.acceptDistance = 2'b00;
    bus.acceptGain     = 2'b00;
    tick(2);
    check("simul_active", 32'(bus.channelActive), 32'd1);
    tick(1);
    check("simul_water", 32'(bus.waterOn), 32'd1);
    tick(3);

    // Asynchronous reset mid-ON.
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_water", 32'(bus.waterOn), 32'd0);
    check("async_rst_active", 32'(bus.channelActive), 32'd0);
    check("async_rst_fault", 32'(bus.timeoutFault), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(5);
    check("post_rst_active", 32'(bus.channelActive), 32'd0);
    check("post_rst_water", 32'(bus.waterOn), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
